sdf_r2_stage: RTL

Parametrised radix-2 single-path-delay-feedback (R2SDF) FFT stage. It accepts one complex sample per valid cycle, performs the decimation-in-frequency butterfly against a D-deep feedback delay line, and multiplies the difference path by an externally supplied twiddle. It produces one complex sample per accepted input with fixed latency. Cascading log2(N) instances, with D halving per stage, forms a streaming N-point FFT and replaces the hand-unrolled per-stage RAM/BF/TF structure of the 256-point design.

---
 rtl/sdf_r2_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path-delay-feedback FFT stage: DIF butterfly against a 2^LOG2_D delay line plus twiddle multiply.
// Define SDF_SCALE_EN to halve each butterfly result (floor); otherwise butterfly results saturate.
module sdf_r2_stage #(
    parameter int DATA_W       = 16,
    parameter int TW_W         = 16,
    parameter int LOG2_D       = 6,
    parameter int TW_STEP_LOG2 = 0
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_r,
    input  logic [DATA_W-1:0]              in_i,
    output logic [LOG2_D+TW_STEP_LOG2-1:0] tw_idx,
    input  logic [TW_W-1:0]                tw_r,
    input  logic [TW_W-1:0]                tw_i,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_r,
    output logic [DATA_W-1:0]              out_i
);

    localparam int D      = 1 << LOG2_D;
    localparam int CNT_W  = LOG2_D + 1;
    localparam int IDX_W  = LOG2_D + TW_STEP_LOG2;
    localparam int PROD_W = DATA_W + TW_W + 1;

    localparam logic [TW_W-1:0]          W_ONE = TW_W'(1) << (TW_W - 2);
    localparam logic signed [PROD_W-1:0] RND   = PROD_W'(1) <<< (TW_W - 3);
    localparam logic signed [PROD_W-1:0] SMAX  = (PROD_W'(1) <<< (DATA_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] SMIN  = ~SMAX;

    logic [CNT_W-1:0]  cnt;
    logic              phase;
    logic [LOG2_D-1:0] k;
    logic              primed;
    logic              acc;
    logic              v1;
    logic              v2;

    logic [DATA_W-1:0] mem_r [D];
    logic [DATA_W-1:0] mem_i [D];
    logic [DATA_W-1:0] h_r, h_i;
    logic [DATA_W:0]   sum_r, sum_i, dif_r, dif_i;
    logic [DATA_W-1:0] wd_r, wd_i;
    logic [DATA_W-1:0] ar, ai;
    logic [TW_W-1:0]   wr, wi;

    logic signed [PROD_W-1:0] ar_x, ai_x, wr_x, wi_x;
    logic signed [PROD_W-1:0] prod_re, prod_im;
    logic signed [PROD_W-1:0] p_r, p_i;

    function automatic logic [DATA_W-1:0] bf_reduce(input logic [DATA_W:0] x);
`ifdef SDF_SCALE_EN
        return x[DATA_W:1];
`else
        if (x[DATA_W] != x[DATA_W-1])
            return {x[DATA_W], {(DATA_W-1){~x[DATA_W]}}};
        else
            return x[DATA_W-1:0];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] round_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] s;
        s = (p + RND) >>> (TW_W - 2);
        if (s > SMAX)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (s < SMIN)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return s[DATA_W-1:0];
    endfunction

    assign phase  = cnt[LOG2_D];
    assign k      = cnt[LOG2_D-1:0];
    assign acc    = in_valid & ~clr;
    assign tw_idx = phase ? '0 : (IDX_W'(k) << TW_STEP_LOG2);

    // Indexing by k makes mem[k] the sample written exactly D accepted inputs ago.
    assign h_r = mem_r[k];
    assign h_i = mem_i[k];

    assign sum_r = {h_r[DATA_W-1], h_r} + {in_r[DATA_W-1], in_r};
    assign sum_i = {h_i[DATA_W-1], h_i} + {in_i[DATA_W-1], in_i};
    assign dif_r = {h_r[DATA_W-1], h_r} - {in_r[DATA_W-1], in_r};
    assign dif_i = {h_i[DATA_W-1], h_i} - {in_i[DATA_W-1], in_i};

    always_comb begin
        ar   = h_r;
        ai   = h_i;
        wr   = tw_r;
        wi   = tw_i;
        wd_r = in_r;
        wd_i = in_i;
        if (phase) begin
            ar   = bf_reduce(sum_r);
            ai   = bf_reduce(sum_i);
            wr   = W_ONE;
            wi   = '0;
            wd_r = bf_reduce(dif_r);
            wd_i = bf_reduce(dif_i);
        end
    end

    assign ar_x    = PROD_W'($signed(ar));
    assign ai_x    = PROD_W'($signed(ai));
    assign wr_x    = PROD_W'($signed(wr));
    assign wi_x    = PROD_W'($signed(wi));
    assign prod_re = ar_x * wr_x - ai_x * wi_x;
    assign prod_im = ar_x * wi_x + ai_x * wr_x;

    always_ff @(posedge CLK) begin
        if (acc) begin
            mem_r[k] <= wd_r;
            mem_i[k] <= wd_i;
        end
    end

    // clr only blocks the incoming sample; whatever is already in flight drains normally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            primed <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            p_r    <= '0;
            p_i    <= '0;
            out_r  <= '0;
            out_i  <= '0;
        end else begin
            v1 <= acc & (phase | primed);
            v2 <= v1;
            if (clr) begin
                cnt    <= '0;
                primed <= 1'b0;
            end else if (in_valid) begin
                cnt <= cnt + CNT_W'(1);
                if (&cnt)
                    primed <= 1'b1;
            end
            if (acc) begin
                p_r <= prod_re;
                p_i <= prod_im;
            end
            if (v1) begin
                out_r <= round_sat(p_r);
                out_i <= round_sat(p_i);
            end
        end
    end

    assign out_valid = v2;

endmodule
